// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared constants and types for the MIPS decode stage.
//   - opcode / funct / rt / rs field values
//   - 12-bit control-word layout, bit index names and CONTROLS_* words
//   - dec_t (decoded fields) and entry_t (one held instruction)
package decode_stage_pkg;

  localparam int CTRL_W = 12;
  localparam int CNT_W  = 6;

  // Control-word bit positions, {memtoreg ... memen} from bit 11 down.
  localparam int C_MEMTOREG  = 11;
  localparam int C_MEMWRITE  = 10;
  localparam int C_BRANCH    = 9;
  localparam int C_ALUSRC    = 8;
  localparam int C_REGDST    = 7;
  localparam int C_REGWRITE  = 6;
  localparam int C_JUMP      = 5;
  localparam int C_HILOWRITE = 4;
  localparam int C_JAL       = 3;
  localparam int C_JR        = 2;
  localparam int C_BAL       = 1;
  localparam int C_MEMEN     = 0;

  localparam logic [CTRL_W-1:0] CONTROLS_RTYPE  = 12'h0C0; // regdst|regwrite
  localparam logic [CTRL_W-1:0] CONTROLS_HILOW  = 12'h010; // hilo_write
  localparam logic [CTRL_W-1:0] CONTROLS_JR     = 12'h004;
  localparam logic [CTRL_W-1:0] CONTROLS_JALR   = 12'h0C4;
  localparam logic [CTRL_W-1:0] CONTROLS_IMM    = 12'h140; // alusrc|regwrite
  localparam logic [CTRL_W-1:0] CONTROLS_LOAD   = 12'h941;
  localparam logic [CTRL_W-1:0] CONTROLS_STORE  = 12'h501;
  localparam logic [CTRL_W-1:0] CONTROLS_BRANCH = 12'h200;
  localparam logic [CTRL_W-1:0] CONTROLS_BAL    = 12'h242;
  localparam logic [CTRL_W-1:0] CONTROLS_J      = 12'h020;
  localparam logic [CTRL_W-1:0] CONTROLS_JAL    = 12'h068;
  localparam logic [CTRL_W-1:0] CONTROLS_MFC0   = 12'h040;

  // Opcodes
  localparam logic [5:0] OP_RTYPE  = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02,
                         OP_JAL    = 6'h03, OP_BEQ    = 6'h04, OP_BNE   = 6'h05,
                         OP_BLEZ   = 6'h06, OP_BGTZ   = 6'h07, OP_ADDI  = 6'h08,
                         OP_ADDIU  = 6'h09, OP_SLTI   = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI   = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E,
                         OP_LUI    = 6'h0F, OP_COP0   = 6'h10, OP_LB    = 6'h20,
                         OP_LH     = 6'h21, OP_LW     = 6'h23, OP_LBU   = 6'h24,
                         OP_LHU    = 6'h25, OP_SB     = 6'h28, OP_SH    = 6'h29,
                         OP_SW     = 6'h2B;

  // R-type funct
  localparam logic [5:0] F_SLL  = 6'h00, F_SRL   = 6'h02, F_SRA  = 6'h03,
                         F_SLLV = 6'h04, F_SRLV  = 6'h06, F_SRAV = 6'h07,
                         F_JR   = 6'h08, F_JALR  = 6'h09, F_SYSCALL = 6'h0C,
                         F_BREAK = 6'h0D, F_MFHI = 6'h10, F_MTHI = 6'h11,
                         F_MFLO = 6'h12, F_MTLO  = 6'h13, F_MULT = 6'h18,
                         F_MULTU = 6'h19, F_DIV  = 6'h1A, F_DIVU = 6'h1B,
                         F_ADD  = 6'h20, F_ADDU  = 6'h21, F_SUB  = 6'h22,
                         F_SUBU = 6'h23, F_AND   = 6'h24, F_OR   = 6'h25,
                         F_XOR  = 6'h26, F_NOR   = 6'h27, F_SLT  = 6'h2A,
                         F_SLTU = 6'h2B, F_ERET  = 6'h18;

  // REGIMM rt, COP0 rs
  localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01,
                         RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;
  localparam logic [4:0] RS_MFC0 = 5'h00, RS_MTC0 = 5'h04, RS_CO = 5'h10;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic              invalid;
    logic              syscall;
    logic              brk;
    logic              eret;
    logic              cp0we;
    logic              is_hilo;
    logic              is_div;
  } dec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    dec_t        dec;
  } entry_t;

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and execute-side handshake bundle of the
// decode stage.
//   slave  : the decode stage (consumes in_*, produces out_*)
//   master : the surrounding pipeline / bench
interface decode_stage_if;
  import decode_stage_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [31:0]       in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_invalid;
  logic              out_syscall;
  logic              out_break;
  logic              out_eret;
  logic              out_cp0we;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_ctrl,
           out_invalid, out_syscall, out_break, out_eret, out_cp0we
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_ctrl,
           out_invalid, out_syscall, out_break, out_eret, out_cp0we
  );
endinterface

// File: rtl/decode_stage_comb.sv
// decode_comb: pure combinational instruction decoder.
//   instr_i      : 32-bit instruction word
//   enable_cp0_i : 0 treats MTC0/MFC0/ERET as reserved
//   dec_o        : control word, exception flags, cp0 write-enable,
//                  is_hilo (touches HI/LO) and is_div (starts the divider)
module decode_comb
  import decode_stage_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic        enable_cp0_i,
  output dec_t        dec_o
);
  logic [5:0] op, funct;
  logic [4:0] rs, rt;
  logic       unused_fields;

  assign op    = instr_i[31:26];
  assign rs    = instr_i[25:21];
  assign rt    = instr_i[20:16];
  assign funct = instr_i[5:0];
  // rd/shamt/immediate bits never affect decode
  assign unused_fields = ^instr_i[15:6];

  always_comb begin
    dec_o = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU: dec_o.ctrl = CONTROLS_RTYPE;
          F_MFHI, F_MFLO: begin
            dec_o.ctrl    = CONTROLS_RTYPE;
            dec_o.is_hilo = 1'b1;
          end
          F_MTHI, F_MTLO, F_MULT, F_MULTU: begin
            dec_o.ctrl    = CONTROLS_HILOW;
            dec_o.is_hilo = 1'b1;
          end
          F_DIV, F_DIVU: begin
            dec_o.ctrl    = CONTROLS_HILOW;
            dec_o.is_hilo = 1'b1;
            dec_o.is_div  = 1'b1;
          end
          F_JR:      dec_o.ctrl    = CONTROLS_JR;
          F_JALR:    dec_o.ctrl    = CONTROLS_JALR;
          F_SYSCALL: dec_o.syscall = 1'b1;
          F_BREAK:   dec_o.brk     = 1'b1;
          default:   dec_o.invalid = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ:     dec_o.ctrl    = CONTROLS_BRANCH;
          RT_BLTZAL, RT_BGEZAL: dec_o.ctrl    = CONTROLS_BAL;
          default:              dec_o.invalid = 1'b1;
        endcase
      end
      OP_J:   dec_o.ctrl = CONTROLS_J;
      OP_JAL: dec_o.ctrl = CONTROLS_JAL;
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: dec_o.ctrl = CONTROLS_BRANCH;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: dec_o.ctrl = CONTROLS_IMM;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: dec_o.ctrl = CONTROLS_LOAD;
      OP_SB, OP_SH, OP_SW: dec_o.ctrl = CONTROLS_STORE;
      OP_COP0: begin
        if (!enable_cp0_i) begin
          dec_o.invalid = 1'b1;
        end else begin
          case (rs)
            RS_MFC0: dec_o.ctrl  = CONTROLS_MFC0;
            RS_MTC0: dec_o.cp0we = 1'b1;
            RS_CO: begin
              if (funct == F_ERET) dec_o.eret    = 1'b1;
              else                 dec_o.invalid = 1'b1;
            end
            default: dec_o.invalid = 1'b1;
          endcase
        end
      end
      default: dec_o.invalid = 1'b1;
    endcase
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered, flow-controlled MIPS decode stage.
//   clk, rst  : clock, synchronous active-high reset
//   flush     : drop everything held (output reg + skid) on the next edge
//   bus       : decode_stage_if.slave -- in_* from fetch, out_* to execute
//   hilo_busy : divide countdown nonzero
// Output register plus a one-entry skid; in_ready is the registered "skid
// empty". A DIV/DIVU leaving the stage arms a DIV_CYCLES countdown during
// which a held HI/LO instruction is not presented downstream.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int DIV_CYCLES     = 36,
  parameter int HILO_INTERLOCK = 1,
  parameter int ENABLE_CP0     = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  decode_stage_if.slave  bus,
  output logic           hilo_busy
);
  localparam logic [CNT_W-1:0] DIV_LOAD = DIV_CYCLES[CNT_W-1:0];

  dec_t             in_dec;
  entry_t           in_e;
  entry_t           out_q, out_d, skid_q, skid_d;
  logic             out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic             in_ready_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy, stall, drain, acc;

  decode_comb u_dec (
    .instr_i      (bus.in_instr),
    .enable_cp0_i (ENABLE_CP0 != 0),
    .dec_o        (in_dec)
  );

  assign in_e  = {bus.in_instr, bus.in_pc, in_dec};
  assign busy  = (cnt_q != '0);
  assign stall = busy && out_q.dec.is_hilo;
  assign drain = bus.out_valid && bus.out_ready;
  assign acc   = bus.in_valid && in_ready_q && !flush;

  always_comb begin
    out_d      = out_q;
    skid_d     = skid_q;
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || drain) begin
      // Output slot frees up: the older skid entry goes first. in_ready is
      // low whenever the skid is full, so no accept can collide with it.
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (acc) begin
        out_d     = in_e;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (acc) begin
      skid_d     = in_e;
      skid_vld_d = 1'b1;
    end
  end

  // The countdown tracks the divider itself, so flush leaves it alone; a DIV
  // handshaking downstream in a flush cycle still started the divider.
  always_comb begin
    cnt_d = cnt_q;
    if (HILO_INTERLOCK != 0 && drain && out_q.dec.is_div) cnt_d = DIV_LOAD;
    else if (busy)                                        cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= !skid_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_vld_q && !stall;
  assign bus.out_instr   = out_q.instr;
  assign bus.out_pc      = out_q.pc;
  assign bus.out_ctrl    = out_q.dec.ctrl;
  assign bus.out_invalid = out_q.dec.invalid;
  assign bus.out_syscall = out_q.dec.syscall;
  assign bus.out_break   = out_q.dec.brk;
  assign bus.out_eret    = out_q.dec.eret;
  assign bus.out_cp0we   = out_q.dec.cp0we;
  assign hilo_busy       = busy;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed bench for decode_stage. A decode table is
// streamed back-to-back, then hand-written sequences cover the HI/LO
// interlock, back-pressure through the skid, flush and reset mid-stall.
// A second instance with ENABLE_CP0=0 checks MTC0 as reserved.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic hilo_busy, hilo_busy2;
  int   checks = 0;
  int   failures = 0;

  decode_stage_if bus ();
  decode_stage_if bus2 ();

  decode_stage #(.DIV_CYCLES(36), .HILO_INTERLOCK(1), .ENABLE_CP0(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus), .hilo_busy(hilo_busy));
  decode_stage #(.DIV_CYCLES(36), .HILO_INTERLOCK(1), .ENABLE_CP0(0)) dut_nocp0 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus2), .hilo_busy(hilo_busy2));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [11:0] ctrl;
    logic [4:0]  flags; // {invalid, syscall, break, eret, cp0we}
  } vec_t;

  vec_t vecs[16];

  localparam logic [31:0] I_DIV  = 32'h0022001A;
  localparam logic [31:0] I_MFLO = 32'h00001812;
  localparam logic [31:0] I_ADDU = 32'h00221821;
  localparam logic [31:0] I_MTC0 = 32'h40815800;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid = v;
    bus.in_instr = instr;
    bus.in_pc    = pc;
  endtask

  initial begin
    int n;
    vecs[0]  = '{32'h24010005, 12'h140, 5'b00000}; // ADDIU
    vecs[1]  = '{32'h8C220004, 12'h941, 5'b00000}; // LW
    vecs[2]  = '{32'hAC220008, 12'h501, 5'b00000}; // SW
    vecs[3]  = '{32'h10220003, 12'h200, 5'b00000}; // BEQ
    vecs[4]  = '{32'h08000010, 12'h020, 5'b00000}; // J
    vecs[5]  = '{32'h0C000010, 12'h068, 5'b00000}; // JAL
    vecs[6]  = '{32'h00221821, 12'h0C0, 5'b00000}; // ADDU
    vecs[7]  = '{32'h03E00008, 12'h004, 5'b00000}; // JR
    vecs[8]  = '{32'hFC000000, 12'h000, 5'b10000}; // reserved opcode
    vecs[9]  = '{32'h0000000C, 12'h000, 5'b01000}; // SYSCALL
    vecs[10] = '{32'h0000000D, 12'h000, 5'b00100}; // BREAK
    vecs[11] = '{32'h42000018, 12'h000, 5'b00010}; // ERET
    vecs[12] = '{32'h40815800, 12'h000, 5'b00001}; // MTC0
    vecs[13] = '{32'h40015800, 12'h040, 5'b00000}; // MFC0
    vecs[14] = '{32'h04310004, 12'h242, 5'b00000}; // BGEZAL
    vecs[15] = '{32'h0000003F, 12'h000, 5'b10000}; // reserved funct

    drive(1'b0, 32'h0, 32'h0);
    bus.out_ready  = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.in_instr  = 32'h0;
    bus2.in_pc     = 32'h0;
    bus2.out_ready = 1'b0;

    // ---- reset state
    step(); step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_ctrl",      32'(bus.out_ctrl),  32'd0);
    chk("rst_pc",        bus.out_pc,         32'd0);
    chk("rst_busy",      32'(hilo_busy),     32'd0);
    rst = 1'b0;

    // ---- decode table, streamed with no bubbles
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, vecs[i].instr, 32'h1000 + 32'(4 * i));
      step();
      chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("tbl%0d_instr", i), bus.out_instr, vecs[i].instr);
      chk($sformatf("tbl%0d_pc", i),    bus.out_pc, 32'h1000 + 32'(4 * i));
      chk($sformatf("tbl%0d_ctrl", i),  32'(bus.out_ctrl), 32'(vecs[i].ctrl));
      chk($sformatf("tbl%0d_flags", i),
          32'({bus.out_invalid, bus.out_syscall, bus.out_break, bus.out_eret, bus.out_cp0we}),
          32'(vecs[i].flags));
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("tbl_empty", 32'(bus.out_valid), 32'd0);

    // ---- DIV then MFLO back to back: MFLO held for DIV_CYCLES cycles
    drive(1'b1, I_DIV, 32'h2000);
    step();
    chk("div_ctrl", 32'(bus.out_ctrl), 32'h010);
    chk("div_valid", 32'(bus.out_valid), 32'd1);
    drive(1'b1, I_MFLO, 32'h2004);
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("div_busy", 32'(hilo_busy), 32'd1);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      n++;
      step();
    end
    chk("mflo_stall_cycles", 32'(n), 32'd36);
    chk("mflo_instr", bus.out_instr, I_MFLO);
    chk("mflo_ctrl", 32'(bus.out_ctrl), 32'h0C0);
    chk("mflo_busy_done", 32'(hilo_busy), 32'd0);
    step();

    // ---- DIV, ADDU, MFLO: ADDU passes while the divider is busy
    drive(1'b1, I_DIV, 32'h3000);
    step();
    drive(1'b1, I_ADDU, 32'h3004);
    step();
    chk("addu_valid", 32'(bus.out_valid), 32'd1);
    chk("addu_instr", bus.out_instr, I_ADDU);
    chk("addu_busy", 32'(hilo_busy), 32'd1);
    drive(1'b1, I_MFLO, 32'h3008);
    step();
    drive(1'b0, 32'h0, 32'h0);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      n++;
      step();
    end
    chk("mflo2_stall_cycles", 32'(n), 32'd35);
    chk("mflo2_pc", bus.out_pc, 32'h3008);
    step();

    // ---- back-pressure through the skid, order 1,2,3
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h24010001, 32'h4000);
    step();
    chk("bp1_instr", bus.out_instr, 32'h24010001);
    chk("bp1_in_ready", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 32'h24010002, 32'h4004);
    step();
    chk("bp2_held", bus.out_instr, 32'h24010001);
    chk("bp2_in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 32'h24010003, 32'h4008);
    step();
    chk("bp3_held", bus.out_instr, 32'h24010001);
    chk("bp3_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    step();
    chk("bp_order2", bus.out_instr, 32'h24010002);
    chk("bp_ready_back", 32'(bus.in_ready), 32'd1);
    step();
    chk("bp_order3", bus.out_instr, 32'h24010003);
    chk("bp_order3_pc", bus.out_pc, 32'h4008);
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("bp_empty", 32'(bus.out_valid), 32'd0);

    // ---- flush with output+skid full and counter at 20
    drive(1'b1, I_DIV, 32'h5000);
    step();
    drive(1'b0, 32'h0, 32'h0);
    step();                      // DIV leaves, counter = 36
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h24010004, 32'h5004);
    step();                      // 35
    drive(1'b1, 32'h24010005, 32'h5008);
    step();                      // 34
    drive(1'b0, 32'h0, 32'h0);
    repeat (14) step();          // 20
    chk("fl_pre_in_ready", 32'(bus.in_ready), 32'd0);
    chk("fl_pre_valid", 32'(bus.out_valid), 32'd1);
    flush = 1'b1;
    drive(1'b1, 32'h24010006, 32'h500C);
    step();                      // 19
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fl_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_in_ready", 32'(bus.in_ready), 32'd1);
    chk("fl_busy", 32'(hilo_busy), 32'd1);
    n = 0;
    while (hilo_busy && n < 200) begin
      step();
      n++;
    end
    chk("fl_count_left", 32'(n), 32'd19);
    chk("fl_dropped", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;

    // ---- reset in the middle of a HI/LO stall
    drive(1'b1, I_DIV, 32'h6000);
    step();
    drive(1'b1, I_MFLO, 32'h6004);
    step();
    drive(1'b0, 32'h0, 32'h0);
    repeat (5) step();
    chk("rs_stalled", 32'(bus.out_valid), 32'd0);
    chk("rs_busy_pre", 32'(hilo_busy), 32'd1);
    rst = 1'b1;
    step();
    chk("rs_valid", 32'(bus.out_valid), 32'd0);
    chk("rs_busy", 32'(hilo_busy), 32'd0);
    chk("rs_instr", bus.out_instr, 32'd0);
    chk("rs_ctrl", 32'(bus.out_ctrl), 32'd0);
    chk("rs_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    step();
    chk("rs_after", 32'(bus.out_valid), 32'd0);

    // ---- ENABLE_CP0=0: MTC0 is reserved
    bus2.out_ready = 1'b1;
    bus2.in_valid  = 1'b1;
    bus2.in_instr  = I_MTC0;
    bus2.in_pc     = 32'h7000;
    step();
    bus2.in_valid  = 1'b0;
    chk("nocp0_valid", 32'(bus2.out_valid), 32'd1);
    chk("nocp0_invalid", 32'(bus2.out_invalid), 32'd1);
    chk("nocp0_cp0we", 32'(bus2.out_cp0we), 32'd0);
    chk("nocp0_ctrl", 32'(bus2.out_ctrl), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
